// File: rtl/add_operand_sequencer.sv
// add_operand_sequencer: loads two operands from a shared bus, then captures the
// external adder's sum together with an unsigned wrap flag.
module add_operand_sequencer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] din,
    input  logic [W-1:0] sum_in,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         done,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, WAIT_B, ADD, DONE} state_t;
    state_t       r_state, w_next;
    logic [W-1:0] r_op_a, r_op_b, r_result;
    logic         r_carry;
    logic         w_cap_a, w_cap_b, w_add;
    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    // clear outranks everything, so no capture enable may fire alongside it
    always_comb begin
        w_cap_a = !clear && load && r_state == IDLE;
        w_cap_b = !clear && load && r_state == WAIT_B;
        w_add   = !clear && r_state == ADD;
        w_next  = r_state;
        case (r_state)
            IDLE:   w_next = load ? WAIT_B : IDLE;
            WAIT_B: w_next = load ? ADD : WAIT_B;
            ADD:    w_next = DONE;
            DONE:   w_next = IDLE;
        endcase
        if (clear) w_next = IDLE;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
        end else begin
            if (w_cap_a) r_op_a <= din;
            if (w_cap_b) r_op_b <= din;
            if (w_add) begin
                r_result <= sum_in;
                r_carry  <= sum_in < r_op_a;
            end
        end
    assign op_a   = r_op_a;
    assign op_b   = r_op_b;
    assign result = r_result;
    assign carry  = r_carry;
    assign done   = r_state == DONE;
    assign busy   = r_state != IDLE;
endmodule

// File: tb/tb_add_operand_sequencer.sv
// tb_add_operand_sequencer: directed table and corner-case sequences for
// add_operand_sequencer, with the downstream adder modelled in the bench.
module tb_add_operand_sequencer;
    localparam int W = 6;
    logic         clk = 1'b0, reset = 1'b0, load = 1'b0, clear = 1'b0;
    logic [W-1:0] din = '0, sum_in, op_a, op_b, result;
    logic         carry, done, busy;
    int           checks = 0, errors = 0;

    add_operand_sequencer #(.W(W)) dut (
        .clk(clk), .reset(reset), .load(load), .clear(clear), .din(din),
        .sum_in(sum_in), .op_a(op_a), .op_b(op_b), .result(result),
        .carry(carry), .done(done), .busy(busy)
    );

    assign sum_in = op_a + op_b;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         cy;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic ld, input logic clr, input logic [W-1:0] d);
        load = ld;
        clear = clr;
        din = d;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        clear = 1'b0;
    endtask

    task automatic outs0(input string tag);
        chk({tag, " op_a"}, op_a, 0);
        chk({tag, " op_b"}, op_b, 0);
        chk({tag, " result"}, result, 0);
        chk({tag, " carry"}, carry, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " busy"}, busy, 0);
    endtask

    initial begin
        int pulses;
        vecs[0] = '{21, 13, 34, 0};
        vecs[1] = '{63, 1, 0, 1};
        vecs[2] = '{40, 30, 6, 1};
        vecs[3] = '{0, 0, 0, 0};
        vecs[4] = '{32, 32, 0, 1};
        vecs[5] = '{63, 63, 62, 1};
        vecs[6] = '{10, 20, 30, 0};

        reset = 1'b1;
        #1;
        outs0("reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // back-to-back pairs at minimum spacing
        pulses = 0;
        foreach (vecs[i]) begin
            cyc(1, 0, vecs[i].a);
            chk("vec op_a", op_a, vecs[i].a);
            chk("vec busy after A", busy, 1);
            cyc(1, 0, vecs[i].b);
            chk("vec op_b", op_b, vecs[i].b);
            chk("vec done early", done, 0);
            cyc(0, 0, 0);
            chk("vec result", result, vecs[i].res);
            chk("vec carry", carry, vecs[i].cy);
            chk("vec done", done, 1);
            pulses += int'(done);
            cyc(0, 0, 0);
            chk("vec done one cycle", done, 0);
            chk("vec busy end", busy, 0);
        end
        chk("done pulse count", pulses, 7);

        // gap between operands, then loads during ADD/DONE are ignored
        cyc(1, 0, 5);
        for (int k = 0; k < 10; k++) cyc(0, 0, 0);
        chk("gap busy", busy, 1);
        chk("gap op_a held", op_a, 5);
        cyc(1, 0, 7);
        cyc(1, 0, 50);
        chk("gap result", result, 12);
        chk("gap done", done, 1);
        chk("ignore op_a in ADD", op_a, 5);
        cyc(1, 0, 51);
        chk("ignore op_a in DONE", op_a, 5);
        chk("ignore op_b", op_b, 7);
        chk("ignore busy", busy, 0);
        cyc(0, 0, 0);
        chk("no second done", done, 0);

        // clear with load in WAIT_B
        cyc(1, 0, 9);
        cyc(1, 1, 4);
        chk("clear busy", busy, 0);
        chk("clear op_b kept", op_b, 7);
        chk("clear op_a kept", op_a, 9);
        cyc(0, 0, 0);
        chk("clear no done", done, 0);
        cyc(1, 0, 11);
        chk("after clear A", op_a, 11);
        cyc(1, 0, 2);
        cyc(0, 0, 0);
        chk("after clear result", result, 13);
        chk("after clear done", done, 1);
        cyc(0, 0, 0);

        // clear while in ADD: result untouched, no done
        cyc(1, 0, 30);
        cyc(1, 0, 3);
        cyc(0, 1, 0);
        chk("clear ADD result", result, 13);
        chk("clear ADD done", done, 0);
        chk("clear ADD busy", busy, 0);

        // async reset while in ADD
        cyc(1, 0, 20);
        cyc(1, 0, 22);
        #2 reset = 1'b1;
        #1;
        outs0("mid reset");
        #1 reset = 1'b0;
        cyc(0, 0, 0);
        chk("post reset done", done, 0);
        cyc(0, 0, 0);
        chk("post reset done2", done, 0);
        chk("post reset result", result, 0);
        cyc(1, 0, 3);
        chk("post reset A", op_a, 3);
        cyc(1, 0, 4);
        cyc(0, 0, 0);
        chk("post reset sum", result, 7);
        chk("post reset sum done", done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
